// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundle between the two ALU requesters, the shared ALU and
// the arbiter.
//   req_*      : per-port request channel (valid/ready, ctrl, operands)
//   alu_*      : operands to the shared combinational ALU and its result
//   rsp_*      : per-port response channel, with a shared data bus
//   busy       : arbiter holds an operation or an unreturned result
// Modports: master = requesters plus the ALU side (the environment),
//           slave  = the arbiter.
interface alu_arbiter_if #(
  parameter int XLEN = 32
);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][31:0]      req_alu_ctrl;
  logic [1:0][XLEN-1:0]  req_a;
  logic [1:0][XLEN-1:0]  req_b;
  logic [31:0]           alu_ctrl;
  logic [XLEN-1:0]       alu_a;
  logic [XLEN-1:0]       alu_b;
  logic [XLEN-1:0]       alu_result;
  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready;
  logic [XLEN-1:0]       rsp_data;
  logic                  busy;

  modport master (
    output req_valid, req_alu_ctrl, req_a, req_b, rsp_ready, alu_result,
    input  req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_alu_ctrl, req_a, req_b, rsp_ready, alu_result,
    output req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational integer ALU between two requesters.
// Port 0 is the execute-stage integer/branch path; port 1 is the address/aux path.
// Requests are granted round-robin. The operands are held in the OP stage for one
// cycle while they drive the ALU, then the ALU result is captured into the RES stage
// and returned to the port that owns it.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : alu_arbiter_if.slave (request, ALU and response channels, busy)
module alu_arbiter #(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);

  logic            op_v;
  logic            op_own;
  logic [31:0]     op_ctrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            res_v;
  logic            res_own;
  logic [XLEN-1:0] res_data;
  logic            last_grant;

  logic            res_drain;
  logic            op_adv;
  logic            accept_en;
  logic            grant_v;
  logic            grant;
  logic [1:0]      ready;
  logic            accept;

  // Only the owning port's rsp_ready can retire the result.
  assign res_drain = res_v & bus.rsp_ready[res_own];
  assign op_adv    = op_v & (~res_v | res_drain);
  assign accept_en = ~op_v | op_adv;

  // With both ports valid, the port that did not win the last accept goes first.
  assign grant_v = |bus.req_valid;
  assign grant   = (bus.req_valid == 2'b11) ? ~last_grant : bus.req_valid[1];

  assign ready  = (rst_n & accept_en & grant_v) ? (2'b01 << grant) : 2'b00;
  assign accept = |(bus.req_valid & ready);

  assign bus.req_ready = ready;
  assign bus.alu_ctrl  = op_v ? op_ctrl : 32'd0;
  assign bus.alu_a     = op_v ? op_a : '0;
  assign bus.alu_b     = op_v ? op_b : '0;
  assign bus.rsp_valid = res_v ? (2'b01 << res_own) : 2'b00;
  assign bus.rsp_data  = res_data;
  assign bus.busy      = op_v | res_v;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_v       <= 1'b0;
      op_own     <= 1'b0;
      op_ctrl    <= 32'd0;
      op_a       <= '0;
      op_b       <= '0;
      res_v      <= 1'b0;
      res_own    <= 1'b0;
      res_data   <= '0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        op_ctrl    <= bus.req_alu_ctrl[grant];
        op_a       <= bus.req_a[grant];
        op_b       <= bus.req_b[grant];
        op_own     <= grant;
        last_grant <= grant;
      end
      // Accept and advance can happen on the same edge, so OP stays full.
      op_v <= accept | (op_v & ~op_adv);
      if (op_adv) begin
        res_data <= bus.alu_result;
        res_own  <= op_own;
        res_v    <= 1'b1;
      end else if (res_drain) begin
        res_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural ALU
// (ADD/SUB/SLT) and an in-flight list model of the two-stage pipeline.
module tb_alu_arbiter;

  localparam logic [31:0] ALU_CTRL_ADD = 32'h0000_0001;
  localparam logic [31:0] ALU_CTRL_SUB = 32'h0000_0002;
  localparam logic [31:0] ALU_CTRL_SLT = 32'h0000_0004;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t q[$];
  logic last_win;

  alu_arbiter_if #(.XLEN(32)) bus ();

  alu_arbiter #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_f(input logic [31:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    case (c)
      ALU_CTRL_ADD: return a + b;
      ALU_CTRL_SUB: return a - b;
      ALU_CTRL_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:      return 32'd0;
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.alu_ctrl, bus.alu_a, bus.alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: the oldest in-flight op must be presented from two cycles after its
  // accept until its owner takes it; busy reflects anything held by the block.
  initial begin
    logic [1:0] exp_valid;
    logic       exp_busy;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1) begin
        exp_valid = 2'b00;
        exp_busy  = 1'b0;
        if (q.size() > 0) begin
          exp_busy = (q[0].acc < cyc);
          if (q[0].acc + 2 <= cyc) exp_valid = q[0].port ? 2'b10 : 2'b01;
        end
        chk("rsp_valid", {30'd0, bus.rsp_valid}, {30'd0, exp_valid});
        chk("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
        if (!exp_busy) chk("alu_a_idle", bus.alu_a, 32'd0);
        if (exp_valid != 2'b00) begin
          chk("rsp_data", bus.rsp_data, q[0].data);
          if (bus.rsp_ready[q[0].port]) void'(q.pop_front());
        end
      end
    end
  end

  // One request cycle: drive at the falling edge, then compare req_ready against the
  // arbitration rule and record every accepted op on the scoreboard.
  task automatic step(input logic [1:0] v,
                      input logic [31:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [31:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                      input logic [1:0] rr, output logic [1:0] rdy);
    logic [1:0] exp_rdy;
    logic       room;
    @(negedge clk);
    bus.req_valid       = v;
    bus.req_alu_ctrl[0] = c0;
    bus.req_a[0]        = a0;
    bus.req_b[0]        = b0;
    bus.req_alu_ctrl[1] = c1;
    bus.req_a[1]        = a1;
    bus.req_b[1]        = b1;
    bus.rsp_ready       = rr;
    #1;
    room = (q.size() < 2) || (rr[q[0].port] == 1'b1);
    if (!room || v == 2'b00) exp_rdy = 2'b00;
    else if (v == 2'b11)     exp_rdy = last_win ? 2'b01 : 2'b10;
    else                     exp_rdy = v;
    chk("req_ready", {30'd0, bus.req_ready}, {30'd0, exp_rdy});
    rdy = bus.req_ready;
    for (int p = 0; p < 2; p++) begin
      if (v[p] && bus.req_ready[p]) begin
        q.push_back('{port: p[0],
                      data: p == 0 ? alu_f(c0, a0, b0) : alu_f(c1, a1, b1),
                      acc: cyc});
        last_win = p[0];
      end
    end
  endtask

  task automatic idle(input int n, input logic [1:0] rr);
    logic [1:0] r;
    for (int i = 0; i < n; i++) step(2'b00, 0, 0, 0, 0, 0, 0, rr, r);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n         = 1'b0;
    bus.req_valid = 2'b00;
    q.delete();
    last_win = 1'b1;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0]  r;
    logic [31:0] seq;
    logic [31:0] pc[2];
    logic [31:0] pa[2];
    logic [31:0] pb[2];
    logic [1:0]  pv;
    logic [31:0] ops[3];

    ops[0] = ALU_CTRL_ADD;
    ops[1] = ALU_CTRL_SUB;
    ops[2] = ALU_CTRL_SLT;
    last_win         = 1'b1;
    rst_n            = 1'b0;
    bus.req_valid    = 2'b11;
    bus.req_alu_ctrl = '0;
    bus.req_a        = '0;
    bus.req_b        = '0;
    bus.rsp_ready    = 2'b00;

    // Reset held with both ports requesting.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    chk("rst_alu_ctrl", bus.alu_ctrl, 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    bus.req_valid = 2'b00;
    rst_n         = 1'b1;

    // Single ADD on port 0: response two cycles after the request cycle.
    step(2'b01, ALU_CTRL_ADD, 5, 7, 0, 0, 0, 2'b11, r);
    idle(1, 2'b11);
    step(2'b00, 0, 0, 0, 0, 0, 0, 2'b11, r);
    chk("single_rsp_valid", {30'd0, bus.rsp_valid}, 32'd1);
    chk("single_rsp_data", bus.rsp_data, 32'd12);
    step(2'b00, 0, 0, 0, 0, 0, 0, 2'b11, r);
    chk("single_busy_low", {31'd0, bus.busy}, 32'd0);

    // Contention: alternating grants, back-to-back responses.
    do_reset(2);
    for (int i = 0; i < 6; i++)
      step(i < 4 ? 2'b11 : 2'b00, ALU_CTRL_ADD, 1, 1, ALU_CTRL_ADD, 10, 10, 2'b11, r);
    idle(2, 2'b11);

    // Back-pressure on port 1 while port 0 fills OP; rsp_ready[0] must not drain it.
    do_reset(2);
    step(2'b10, 0, 0, 0, ALU_CTRL_SLT, 32'hFFFF_FFFF, 0, 2'b01, r);
    step(2'b01, ALU_CTRL_ADD, 3, 4, 0, 0, 0, 2'b01, r);
    for (int i = 0; i < 5; i++) begin
      step(2'b01, ALU_CTRL_ADD, 100, 1, 0, 0, 0, 2'b01, r);
      chk("bp_held_data", bus.rsp_data, 32'd1);
    end
    step(2'b01, ALU_CTRL_ADD, 100, 1, 0, 0, 0, 2'b11, r);
    idle(4, 2'b11);

    // Full pipeline releasing while a new request arrives: sequence must be gapless.
    do_reset(2);
    seq = 0;
    for (int i = 0; i < 12; i++) begin
      step(2'b01, ALU_CTRL_ADD, seq, 0, 0, 0, 0, i < 3 ? 2'b00 : 2'b11, r);
      if (r[0]) seq = seq + 1;
    end
    chk("seq_count", seq, 32'd11);
    idle(3, 2'b11);

    // Reset with OP and RES both occupied.
    do_reset(2);
    step(2'b01, ALU_CTRL_ADD, 1, 1, 0, 0, 0, 2'b00, r);
    step(2'b01, ALU_CTRL_ADD, 2, 2, 0, 0, 0, 2'b00, r);
    step(2'b00, 0, 0, 0, 0, 0, 0, 2'b00, r);
    chk("full_busy", {31'd0, bus.busy}, 32'd1);
    do_reset(1);
    #1;
    chk("midrst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    step(2'b11, ALU_CTRL_ADD, 3, 3, ALU_CTRL_ADD, 4, 4, 2'b11, r);
    chk("midrst_first_grant", {30'd0, r}, 32'd1);
    idle(3, 2'b11);

    // Randomised traffic; payload held stable until accepted or valid is dropped.
    do_reset(2);
    pv = 2'b00;
    for (int p = 0; p < 2; p++) begin
      pc[p] = 0;
      pa[p] = 0;
      pb[p] = 0;
    end
    for (int i = 0; i < 500; i++) begin
      step(pv, pc[0], pa[0], pb[0], pc[1], pa[1], pb[1],
           2'($urandom_range(0, 3)) | (($urandom % 3 != 0) ? 2'b11 : 2'b00), r);
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] || r[p]) begin
          pv[p] = ($urandom % 3) != 0;
          pc[p] = ops[$urandom % 3];
          pa[p] = ($urandom % 2 == 0) ? $urandom : 32'($urandom_range(0, 15)) - 32'd8;
          pb[p] = ($urandom % 2 == 0) ? $urandom : 32'($urandom_range(0, 15)) - 32'd8;
        end else if ($urandom % 8 == 0) begin
          pv[p] = 1'b0;
        end
      end
    end
    idle(6, 2'b11);
    chk("drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
